inst_fetch: RTL



---
 rtl/fetch_pkg.sv | 22 ++
 rtl/inst_fetch.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage and its neighbours (decode, ImmGen).
package fetch_pkg;

  // Fetch FSM state encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_OUT   = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_e;

  // Every instruction occupies one 32-bit word.
  localparam int unsigned INST_BYTES = 4;

  // RV32/RV64 major opcodes referenced by decode and the immediate generator.
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding memory request at a time, a single
// output slot towards decode, and redirects accepted at any point of a fetch.
// A redirect that overtakes an in-flight request parks the FSM in DRAIN until
// the stale response has been swallowed.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int                INST_W   = 32,
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_valid,
  input  logic [INST_W-1:0] i_imem_inst,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_busy
);

  // Redirect targets are always word aligned; the low address bits are cleared.
  function automatic logic [ADDR_W-1:0] align_target(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(INST_BYTES - 1);
  endfunction

  // Sequential successor; wraps silently at the top of the address space.
  function automatic logic [ADDR_W-1:0] next_seq_pc(input logic [ADDR_W-1:0] addr);
    return addr + ADDR_W'(INST_BYTES);
  endfunction

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic [INST_W-1:0] out_inst_q, out_inst_d;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              xfer;

  assign redirect_tgt = align_target(i_redirect_pc);
  assign xfer         = (state_q == ST_OUT) && i_inst_ready;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // PC and output-slot registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q       <= '0;
      out_pc_q   <= '0;
      out_inst_q <= '0;
    end else begin
      pc_q       <= pc_d;
      out_pc_q   <= out_pc_d;
      out_inst_q <= out_inst_d;
    end
  end

  // Next-state and next-PC selection; redirect always wins over sequential flow.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    out_pc_d   = out_pc_q;
    out_inst_d = out_inst_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          pc_d    = RESET_PC;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // The request has gone out this cycle, so a redirect must drain it.
        if (i_redirect) begin
          pc_d    = redirect_tgt;
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_redirect) begin
          // A coincident response is the stale one: nothing left to drain.
          pc_d    = redirect_tgt;
          state_d = i_imem_valid ? ST_REQ : ST_DRAIN;
        end else if (i_imem_valid) begin
          out_inst_d = i_imem_inst;
          out_pc_d   = pc_q;
          state_d    = ST_OUT;
        end
      end
      ST_DRAIN: begin
        if (i_redirect) begin
          pc_d = redirect_tgt;
        end
        if (i_imem_valid) begin
          state_d = ST_REQ;
        end
      end
      ST_OUT: begin
        // A transfer in the same cycle as a redirect still completes.
        if (i_redirect) begin
          pc_d    = redirect_tgt;
          state_d = ST_REQ;
        end else if (xfer) begin
          pc_d    = next_seq_pc(pc_q);
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_imem_req   = (state_q == ST_REQ);
  assign o_imem_addr  = (state_q == ST_REQ) ? pc_q : '0;
  assign o_inst_valid = (state_q == ST_OUT);
  assign o_inst       = out_inst_q;
  assign o_pc         = out_pc_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule
